fetch_stage_pipelined: RTL and testbench
========================================

// Module: fetch_stage_pipelined
// PURPOSE
//  Parametrised next-generation MIPS fetch stage: PC register, 4-way next-PC select, instruction
//  memory with a load port, and a registered IF/ID output with valid, stall, flush and single-step.
//  Sits between the debug/loader unit (program load, start, step) and the decode stage; the hazard
//  unit drives stall, and the branch/jump logic drives redirect and flush.
// PARAMETERS
//  LEN        32            data/PC width in bits
//  DEPTH      2048          instruction memory depth in words (power of two)
//  ADDR_W     $clog2(DEPTH) word-address width
//  HALT_WORD  32'hFFFF_FFFF encoding of the halt instruction (used only when halt detect is compiled in)
// PORTS
//  clk             in   1       clock, all state changes on posedge
//  reset           in   1       asynchronous, active-high
//  in_start        in   1       start/restart fetch from PC=0 (IDLE/HALT only)
//  in_step_mode    in   1       1: advance only on in_step pulses
//  in_step         in   1       single-step strobe (1 cycle)
//  in_stall        in   1       hazard stall: hold PC and IF/ID
//  in_flush        in   1       squash the IF/ID contents (taken branch/jump)
//  in_pc_src       in   2       00 PC+4, 01 jump, 10 branch, 11 register
//  in_pc_jump      in   LEN     jump target
//  in_pc_branch    in   LEN     branch target
//  in_pc_register  in   LEN     jr/jalr target
//  in_load_we      in   1       program-load write enable
//  in_load_addr    in   ADDR_W  program-load word address
//  in_load_data    in   LEN     program-load data
//  out_pc          out  LEN     PC of the instruction in IF/ID
//  out_pc_branch   out  LEN     PC+4 of the instruction in IF/ID
//  out_instruction out  LEN     fetched instruction (IF/ID)
//  out_valid       out  1       IF/ID holds a real instruction
//  out_state       out  2       FSM state (IDLE=0, RUN=1, HALT=2)
//  out_halted      out  1       state==HALT
// BEHAVIOUR
//  - Reset: PC=0, state=IDLE, every out_* = 0 (out_instruction = NOP 0). Memory contents are not cleared.
//    Reset asserted mid-run aborts immediately; memory writes in progress in that cycle are dropped.
//  - FSM: IDLE --in_start--> RUN; RUN --halt word fetched--> HALT; HALT --in_start--> RUN.
//    Entering RUN sets PC=0 and clears IF/ID (valid=0).
//  - Load port: writes mem[in_load_addr] only in IDLE/HALT; ignored in RUN.
//  - advance = RUN && !in_stall && (!in_step_mode || in_step).
//  - On an advance posedge: out_instruction<=mem[PC[ADDR_W+1:2]]; out_pc<=PC; out_pc_branch<=PC+4;
//    out_valid<=1; PC<=mux(in_pc_src). One-cycle latency from PC to IF/ID; synchronous read.
//  - Flush (RUN) beats stall and step gating: IF/ID<=NOP, out_valid<=0, PC<=mux(in_pc_src).
//  - No advance and no flush: PC and all IF/ID outputs hold (valid unchanged).
//  - Arithmetic: PC+4 wraps modulo 2^LEN; PC[1:0] ignored for addressing; word index truncates,
//    so addresses >= DEPTH*4 wrap.
// CONFIGURATION
//  FETCH_HALT_DETECT_EN defined: on an advance where the memory word == HALT_WORD, the word is latched
//    with out_valid=1, PC holds at the halt address, and state goes RUN->HALT in the same cycle.
//    Flush in that cycle wins: no halt, normal flush.
//  Not defined: HALT is unreachable, HALT_WORD is fetched as an ordinary word, out_halted is tied 0.
// STRUCTURE
//  - Package fetch_pkg: PC_SRC_{PC4,JUMP,BRANCH,REG} encodings, ST_{IDLE,RUN,HALT}, NOP_WORD=0.
//  - Sub-module instr_mem_sdp: simple dual-port RAM (write port = load, sync read port = fetch
//    with read-enable = advance). The FSM, PC and IF/ID register stay in the top module.
// TESTING
//  1 Load mem[0..3]=11,22,33,44; start; step_mode=0 -> out_instruction 11,22,33,44 on consecutive cycles,
//    out_pc 0,4,8,12, out_pc_branch 4,8,12,16, valid=1.
//  2 Stall 2 cycles while PC=8 -> outputs frozen at (4,22) for 2 cycles, then 33 with PC=8.
//  3 At PC=4, pc_src=01, jump=0x40, flush=1 -> next cycle valid=0, instr=0; following cycle out_pc=0x40.
//  4 step_mode=1, 3 step pulses spaced 5 cycles apart -> exactly 3 advances, outputs hold between them.
//  5 (FETCH_HALT_DETECT_EN) mem[2]=FFFF_FFFF -> halt word latched with valid=1, state=HALT,
//    out_pc stays 8, load write accepted; in_start -> restart at PC=0.
//  6 Reset asserted mid-RUN -> all outputs 0 asynchronously, state=IDLE; a load write in RUN is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the pipelined fetch stage: next-PC select, FSM states, NOP word.
package fetch_pkg;

  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_PC4    = 2'b00,
    PC_SRC_JUMP   = 2'b01,
    PC_SRC_BRANCH = 2'b10,
    PC_SRC_REG    = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_stage_pipelined_if.sv
// Control/load/IF-ID bundle between debug unit, hazard/branch logic, fetch stage and decode.
interface fetch_stage_pipelined_if #(
  parameter int unsigned LEN    = 32,
  parameter int unsigned ADDR_W = 11
);

  logic              in_start;
  logic              in_step_mode;
  logic              in_step;
  logic              in_stall;
  logic              in_flush;
  logic [1:0]        in_pc_src;
  logic [LEN-1:0]    in_pc_jump;
  logic [LEN-1:0]    in_pc_branch;
  logic [LEN-1:0]    in_pc_register;
  logic              in_load_we;
  logic [ADDR_W-1:0] in_load_addr;
  logic [LEN-1:0]    in_load_data;

  logic [LEN-1:0]    out_pc;
  logic [LEN-1:0]    out_pc_branch;
  logic [LEN-1:0]    out_instruction;
  logic              out_valid;
  logic [1:0]        out_state;
  logic              out_halted;

  // Driver side: loader, hazard and branch units plus the decode-stage observer
  modport master (
    output in_start, in_step_mode, in_step, in_stall, in_flush, in_pc_src,
           in_pc_jump, in_pc_branch, in_pc_register, in_load_we, in_load_addr, in_load_data,
    input  out_pc, out_pc_branch, out_instruction, out_valid, out_state, out_halted
  );

  // Fetch stage side
  modport slave (
    input  in_start, in_step_mode, in_step, in_stall, in_flush, in_pc_src,
           in_pc_jump, in_pc_branch, in_pc_register, in_load_we, in_load_addr, in_load_data,
    output out_pc, out_pc_branch, out_instruction, out_valid, out_state, out_halted
  );

endinterface

// File: rtl/instr_mem_sdp.sv
// Simple dual-port instruction RAM: write port for program load, registered read port
// that doubles as the IF/ID instruction register (cleared to NOP on reset/clear).
module instr_mem_sdp
  import fetch_pkg::*;
#(
  parameter int unsigned    LEN       = 32,
  parameter int unsigned    DEPTH     = 2048,
  parameter int unsigned    ADDR_W    = $clog2(DEPTH),
  parameter logic [LEN-1:0] HALT_WORD = LEN'(32'hFFFF_FFFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [LEN-1:0]    i_wdata,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [LEN-1:0]    o_rdata,
  output logic              o_halt_hit_c
);

  logic [LEN-1:0] r_mem [DEPTH];
  logic [LEN-1:0] r_rdata;

  // Load-port write; array has no reset so contents survive a reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Fetch read register: clear beats read, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= LEN'(NOP_WORD);
    end else if (i_clr) begin
      r_rdata <= LEN'(NOP_WORD);
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata      = r_rdata;
  // Look-ahead compare on the word about to be fetched, used for same-cycle halt
  assign o_halt_hit_c = (r_mem[i_raddr] == HALT_WORD);

endmodule

// File: rtl/fetch_stage_pipelined.sv
// Pipelined MIPS fetch stage: PC register, 4-way next-PC select, instruction RAM with load
// port, and IF/ID register with valid, stall, flush and single-step.
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching (RUN->HALT) when HALT_WORD
// is fetched; otherwise HALT is unreachable and out_halted is tied low.
module fetch_stage_pipelined
  import fetch_pkg::*;
#(
  parameter int unsigned    LEN       = 32,
  parameter int unsigned    DEPTH     = 2048,
  parameter int unsigned    ADDR_W    = $clog2(DEPTH),
  parameter logic [LEN-1:0] HALT_WORD = LEN'(32'hFFFF_FFFF)
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_stage_pipelined_if.slave   bus
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_e            r_state;
  logic [LEN-1:0]    r_pc;
  logic [LEN-1:0]    r_out_pc;
  logic [LEN-1:0]    r_out_pc_branch;
  logic              r_valid;

  logic              w_run;
  logic              w_start;
  logic              w_advance;
  logic              w_flush;
  logic              w_halt;
  logic              w_halt_hit_c;
  logic              w_mem_re;
  logic              w_mem_clr;
  logic              w_load_we;
  logic [LEN-1:0]    w_pc_plus4;
  logic [LEN-1:0]    w_pc_next;
  logic [LEN-1:0]    w_instr;
  logic [ADDR_W-1:0] w_fetch_idx;

  assign w_run       = (r_state == ST_RUN);
  assign w_start     = !w_run && bus.in_start;
  assign w_advance   = w_run && !bus.in_stall && (!bus.in_step_mode || bus.in_step);
  assign w_flush     = w_run && bus.in_flush;
  assign w_halt      = HALT_EN && w_advance && !w_flush && w_halt_hit_c;
  assign w_pc_plus4  = r_pc + LEN'(PC_STEP);
  assign w_fetch_idx = r_pc[ADDR_W+1:2];
  assign w_mem_re    = w_advance && !w_flush;
  assign w_mem_clr   = w_flush || w_start;
  // Loads only while not fetching; a write coinciding with reset is dropped
  assign w_load_we   = bus.in_load_we && !w_run && !reset;

  // Next-PC select
  always_comb begin
    w_pc_next = w_pc_plus4;
    case (pc_src_e'(bus.in_pc_src))
      PC_SRC_PC4:    w_pc_next = w_pc_plus4;
      PC_SRC_JUMP:   w_pc_next = bus.in_pc_jump;
      PC_SRC_BRANCH: w_pc_next = bus.in_pc_branch;
      PC_SRC_REG:    w_pc_next = bus.in_pc_register;
      default:       w_pc_next = w_pc_plus4;
    endcase
  end

  instr_mem_sdp #(
    .LEN       (LEN),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .HALT_WORD (HALT_WORD)
  ) u_mem (
    .clk          (clk),
    .reset        (reset),
    .i_we         (w_load_we),
    .i_waddr      (bus.in_load_addr),
    .i_wdata      (bus.in_load_data),
    .i_re         (w_mem_re),
    .i_clr        (w_mem_clr),
    .i_raddr      (w_fetch_idx),
    .o_rdata      (w_instr),
    .o_halt_hit_c (w_halt_hit_c)
  );

  // Control FSM with PC and IF/ID side-band registers; flush beats stall/step gating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_pc            <= '0;
      r_out_pc        <= '0;
      r_out_pc_branch <= '0;
      r_valid         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (bus.in_start) begin
            r_state         <= ST_RUN;
            r_pc            <= '0;
            r_out_pc        <= '0;
            r_out_pc_branch <= '0;
            r_valid         <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_flush) begin
            r_pc            <= w_pc_next;
            r_out_pc        <= '0;
            r_out_pc_branch <= '0;
            r_valid         <= 1'b0;
          end else if (w_advance) begin
            r_out_pc        <= r_pc;
            r_out_pc_branch <= w_pc_plus4;
            r_valid         <= 1'b1;
            if (w_halt) begin
              r_state <= ST_HALT;
            end else begin
              r_pc <= w_pc_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_pc          = r_out_pc;
  assign bus.out_pc_branch   = r_out_pc_branch;
  assign bus.out_instruction = w_instr;
  assign bus.out_valid       = r_valid;
  assign bus.out_state       = r_state;

`ifdef FETCH_HALT_DETECT_EN
  assign bus.out_halted = (r_state == ST_HALT);
`else
  assign bus.out_halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage_pipelined.sv
// Directed bench for fetch_stage_pipelined: load, run, stall, flush/jump, PC wrap,
// single-step, mid-run reset, load gating and (when compiled in) halt detection.
module tb_fetch_stage_pipelined;

  localparam int unsigned LEN    = 32;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned ADDR_W = 11;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fetch_stage_pipelined_if #(.LEN(LEN), .ADDR_W(ADDR_W)) bus ();

  fetch_stage_pipelined #(
    .LEN       (LEN),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] br,
                          input logic [31:0] instr, input logic valid);
    chk({tag, ".pc"},    bus.out_pc,          pc);
    chk({tag, ".br"},    bus.out_pc_branch,   br);
    chk({tag, ".instr"}, bus.out_instruction, instr);
    chk({tag, ".valid"}, 32'(bus.out_valid),  32'(valid));
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.in_load_we   = 1'b1;
    bus.in_load_addr = a;
    bus.in_load_data = d;
    tick();
    bus.in_load_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start();
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
  endtask

  logic [31:0] step_words [3];

  initial begin
    n_vec = 0;
    n_err = 0;
    step_words[0] = 32'd11;
    step_words[1] = 32'd22;
    step_words[2] = 32'd33;
    reset = 1'b1;
    bus.in_start       = 1'b0;
    bus.in_step_mode   = 1'b0;
    bus.in_step        = 1'b0;
    bus.in_stall       = 1'b0;
    bus.in_flush       = 1'b0;
    bus.in_pc_src      = 2'b00;
    bus.in_pc_jump     = '0;
    bus.in_pc_branch   = '0;
    bus.in_pc_register = '0;
    bus.in_load_we     = 1'b0;
    bus.in_load_addr   = '0;
    bus.in_load_data   = '0;
    tick();
    tick();

    // Reset state
    chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst.state",  32'(bus.out_state),  32'd0);
    chk("rst.halted", 32'(bus.out_halted), 32'd0);
    reset = 1'b0;

    // Program load in IDLE
    load(11'd0, 32'd11);
    load(11'd1, 32'd22);
    load(11'd2, 32'd33);
    load(11'd3, 32'd44);
    load(11'd16, 32'h55);
    load(11'd2047, 32'hAA);

    // Free run from PC=0
    start();
    chk("t1.state", 32'(bus.out_state), 32'd1);
    chk("t1.v0", 32'(bus.out_valid), 32'd0);
    tick(); chk_ifid("t1.a", 32'd0,  32'd4,  32'd11, 1'b1);
    tick(); chk_ifid("t1.b", 32'd4,  32'd8,  32'd22, 1'b1);
    tick(); chk_ifid("t1.c", 32'd8,  32'd12, 32'd33, 1'b1);
    tick(); chk_ifid("t1.d", 32'd12, 32'd16, 32'd44, 1'b1);

    // Stall for two cycles while PC=8
    do_reset();
    start();
    tick(); tick();
    bus.in_stall = 1'b1;
    tick(); chk_ifid("t2.s1", 32'd4, 32'd8, 32'd22, 1'b1);
    tick(); chk_ifid("t2.s2", 32'd4, 32'd8, 32'd22, 1'b1);
    bus.in_stall = 1'b0;
    tick(); chk_ifid("t2.go", 32'd8, 32'd12, 32'd33, 1'b1);

    // Jump with flush at PC=4
    do_reset();
    start();
    tick(); chk_ifid("t3.pre", 32'd0, 32'd4, 32'd11, 1'b1);
    bus.in_pc_src  = 2'b01;
    bus.in_pc_jump = 32'h40;
    bus.in_flush   = 1'b1;
    tick();
    chk("t3.fl.valid", 32'(bus.out_valid), 32'd0);
    chk("t3.fl.instr", bus.out_instruction, 32'd0);
    bus.in_flush  = 1'b0;
    bus.in_pc_src = 2'b00;
    tick(); chk_ifid("t3.tgt", 32'h40, 32'h44, 32'h55, 1'b1);

    // Branch beyond DEPTH*4 wraps the word index; low PC bits ignored
    bus.in_pc_src    = 2'b10;
    bus.in_pc_branch = 32'h0000_2002;
    tick();
    bus.in_pc_src      = 2'b11;
    bus.in_pc_register = 32'hFFFF_FFFC;
    tick(); chk_ifid("wrap.idx", 32'h2002, 32'h2006, 32'd11, 1'b1);
    bus.in_pc_src = 2'b00;
    tick(); chk_ifid("wrap.pc4", 32'hFFFF_FFFC, 32'h0, 32'hAA, 1'b1);
    tick(); chk_ifid("wrap.zero", 32'd0, 32'd4, 32'd11, 1'b1);

    // Flush beats stall
    bus.in_stall = 1'b1;
    bus.in_flush = 1'b1;
    tick(); chk("fs.valid", 32'(bus.out_valid), 32'd0);
    bus.in_flush = 1'b0;
    tick(); chk("fs.hold", 32'(bus.out_valid), 32'd0);
    bus.in_stall = 1'b0;
    tick(); chk_ifid("fs.go", 32'd8, 32'd12, 32'd33, 1'b1);

    // Single-step: three pulses five cycles apart
    do_reset();
    start();
    bus.in_step_mode = 1'b1;
    tick(); tick();
    chk("st.idle", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.in_step = 1'b1;
      tick();
      bus.in_step = 1'b0;
      chk_ifid("st.adv", 32'(4 * k), 32'(4 * k + 4), step_words[k], 1'b1);
      for (int j = 0; j < 4; j++) tick();
      chk_ifid("st.hold", 32'(4 * k), 32'(4 * k + 4), step_words[k], 1'b1);
    end
    bus.in_step_mode = 1'b0;

    // Asynchronous reset mid-RUN; a load write during reset is dropped
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    chk_ifid("ar", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("ar.state", 32'(bus.out_state), 32'd0);
    bus.in_load_we   = 1'b1;
    bus.in_load_addr = 11'd1;
    bus.in_load_data = 32'h77;
    tick();
    reset = 1'b0;
    bus.in_load_we = 1'b0;

    // Load writes in RUN are ignored
    start();
    bus.in_load_we   = 1'b1;
    bus.in_load_addr = 11'd0;
    bus.in_load_data = 32'h99;
    tick(); chk_ifid("ld.a", 32'd0, 32'd4, 32'd11, 1'b1);
    bus.in_load_we = 1'b0;
    tick(); chk_ifid("ld.b", 32'd4, 32'd8, 32'd22, 1'b1);
    do_reset();
    start();
    tick(); chk_ifid("ld.c", 32'd0, 32'd4, 32'd11, 1'b1);

    // Halt word at mem[2]
    do_reset();
    load(11'd2, 32'hFFFF_FFFF);
    start();
    tick(); tick();
    tick(); chk_ifid("h.word", 32'd8, 32'd12, 32'hFFFF_FFFF, 1'b1);
`ifdef FETCH_HALT_DETECT_EN
    chk("h.state",  32'(bus.out_state),  32'd2);
    chk("h.halted", 32'(bus.out_halted), 32'd1);
    tick(); chk_ifid("h.hold", 32'd8, 32'd12, 32'hFFFF_FFFF, 1'b1);
    chk("h.state2", 32'(bus.out_state), 32'd2);
    load(11'd2, 32'd33);
    start();
    chk("h.rs.state", 32'(bus.out_state), 32'd1);
    chk("h.rs.valid", 32'(bus.out_valid), 32'd0);
    tick(); tick();
    tick(); chk_ifid("h.rs", 32'd8, 32'd12, 32'd33, 1'b1);
`else
    chk("h.state",  32'(bus.out_state),  32'd1);
    chk("h.halted", 32'(bus.out_halted), 32'd0);
    tick(); chk_ifid("h.next", 32'd12, 32'd16, 32'd44, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
